// File: rtl/decode_serialize_controller.sv
// decode_serialize_controller: holds decode for serialized micro-ops, drains the back-end, grants one slot, waits for retire.
// Optional stall-cycle counter enabled by defining RSD_SERIALIZE_PERF_COUNTER_EN.
`default_nettype none

module decode_serialize_controller #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 11,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serialReq,
    input  logic                  backendEmpty,
    input  logic                  downstreamStall,
    input  logic                  serialRetired,
    input  logic                  flush,
    output logic                  decodeHold,
    output logic                  serialGrant,
    output logic                  youngerBlock,
    output logic [1:0]            state,
    output logic                  timeoutErr
`ifdef RSD_SERIALIZE_PERF_COUNTER_EN
    ,
    output logic [PERF_WIDTH-1:0] serialStallCycles
`endif
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DRAIN       = 2'd1,
        GRANT       = 2'd2,
        WAIT_RETIRE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ERR = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    if (((1 << CNT_WIDTH) <= TIMEOUT_CYCLES) || (PERF_WIDTH < 1)) begin : g_bad_params
        $error("decode_serialize_controller: invalid CNT_WIDTH/PERF_WIDTH");
    end

    state_t               cur_state;
    state_t               next_state;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 next_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state  <= IDLE;
            wait_cnt   <= '0;
            timeoutErr <= 1'b0;
        end else begin
            cur_state  <= next_state;
            wait_cnt   <= next_cnt;
            timeoutErr <= next_timeout;
        end
    end

    assign cnt_inc = (wait_cnt >= CNT_MAX) ? CNT_MAX : wait_cnt + CNT_WIDTH'(1);
    assign state   = cur_state;

    always_comb begin
        next_state   = cur_state;
        next_cnt     = wait_cnt;
        next_timeout = timeoutErr;
        decodeHold   = 1'b0;
        serialGrant  = 1'b0;
        youngerBlock = 1'b0;

        case (cur_state)
            IDLE: begin
                // Hold in the same cycle the op appears so it never slips through unguarded.
                decodeHold = serialReq & ~flush;
                if (serialReq) begin
                    next_state = DRAIN;
                    next_cnt   = '0;
                end
            end
            DRAIN: begin
                decodeHold = 1'b1;
                if (!serialReq) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (backendEmpty && !downstreamStall) begin
                    next_state = GRANT;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_inc;
                    if (cnt_inc >= CNT_ERR) begin
                        next_timeout = 1'b1;
                    end
                end
            end
            GRANT: begin
                youngerBlock = 1'b1;
                serialGrant  = ~downstreamStall & ~flush;
                if (!downstreamStall) begin
                    next_state = WAIT_RETIRE;
                    next_cnt   = '0;
                end
            end
            WAIT_RETIRE: begin
                decodeHold   = 1'b1;
                youngerBlock = 1'b1;
                if (serialRetired) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_inc;
                    if (cnt_inc >= CNT_ERR) begin
                        next_timeout = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase

        // Flush overrides every transition; the sticky error is left untouched.
        if (flush) begin
            next_state   = IDLE;
            next_cnt     = '0;
            next_timeout = timeoutErr;
        end
    end

`ifdef RSD_SERIALIZE_PERF_COUNTER_EN
    logic [PERF_WIDTH-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (decodeHold && (stall_cnt != {PERF_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + PERF_WIDTH'(1);
        end
    end

    assign serialStallCycles = stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_serialize_controller.sv
// Table-driven bench for decode_serialize_controller (TIMEOUT_CYCLES=16).
`default_nettype none

module tb_decode_serialize_controller;

    logic        clk;
    logic        rst;
    logic        serialReq;
    logic        backendEmpty;
    logic        downstreamStall;
    logic        serialRetired;
    logic        flush;
    logic        decodeHold;
    logic        serialGrant;
    logic        youngerBlock;
    logic [1:0]  state;
    logic        timeoutErr;
`ifdef RSD_SERIALIZE_PERF_COUNTER_EN
    logic [31:0] serialStallCycles;
`endif

    int tests = 0;
    int fails = 0;

    decode_serialize_controller #(
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH(5),
        .PERF_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .serialReq(serialReq),
        .backendEmpty(backendEmpty),
        .downstreamStall(downstreamStall),
        .serialRetired(serialRetired),
        .flush(flush),
        .decodeHold(decodeHold),
        .serialGrant(serialGrant),
        .youngerBlock(youngerBlock),
        .state(state),
        .timeoutErr(timeoutErr)
`ifdef RSD_SERIALIZE_PERF_COUNTER_EN
        ,
        .serialStallCycles(serialStallCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {serialReq, backendEmpty, downstreamStall, serialRetired, flush}
    // exp = {state[1:0], decodeHold, serialGrant, youngerBlock, timeoutErr}, sampled before the edge
    typedef struct {
        logic [4:0] in;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] in, input logic [5:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: inputs change on the falling edge, outputs sampled 2ns later.
    task automatic drive(input logic [4:0] in);
        @(negedge clk);
        {serialReq, backendEmpty, downstreamStall, serialRetired, flush} = in;
        #2;
    endtask

    function automatic logic [5:0] outs();
        return {state, decodeHold, serialGrant, youngerBlock, timeoutErr};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        {serialReq, backendEmpty, downstreamStall, serialRetired, flush} = 5'b0;

        // Basic
        add(5'b00000, 6'b00_0000);
        add(5'b11000, 6'b00_1000);
        add(5'b11000, 6'b01_1000);
        add(5'b11000, 6'b10_0110);
        add(5'b00000, 6'b11_1010);
        add(5'b00010, 6'b11_1010);
        add(5'b00000, 6'b00_0000);
        // Drain wait for 5 cycles
        add(5'b10000, 6'b00_1000);
        for (int i = 0; i < 5; i++) add(5'b10000, 6'b01_1000);
        add(5'b11000, 6'b01_1000);
        add(5'b11000, 6'b10_0110);
        add(5'b00010, 6'b11_1010);
        add(5'b00000, 6'b00_0000);
        // Grant stalled 3 cycles, retire ignored in GRANT
        add(5'b11000, 6'b00_1000);
        add(5'b11000, 6'b01_1000);
        add(5'b11110, 6'b10_0010);
        add(5'b11100, 6'b10_0010);
        add(5'b11100, 6'b10_0010);
        add(5'b11000, 6'b10_0110);
        add(5'b00010, 6'b11_1010);
        add(5'b00000, 6'b00_0000);
        // Flush in GRANT
        add(5'b11000, 6'b00_1000);
        add(5'b11000, 6'b01_1000);
        add(5'b11001, 6'b10_0010);
        add(5'b00000, 6'b00_0000);
        // Flush with retire in WAIT_RETIRE
        add(5'b11000, 6'b00_1000);
        add(5'b11000, 6'b01_1000);
        add(5'b11000, 6'b10_0110);
        add(5'b00011, 6'b11_1010);
        add(5'b00000, 6'b00_0000);
        // Flush in IDLE masks the Mealy hold; flush in DRAIN
        add(5'b11001, 6'b00_0000);
        add(5'b00000, 6'b00_0000);
        add(5'b10000, 6'b00_1000);
        add(5'b10001, 6'b01_1000);
        add(5'b00000, 6'b00_0000);
        // serialReq drops mid-DRAIN
        add(5'b10000, 6'b00_1000);
        add(5'b00000, 6'b01_1000);
        add(5'b00000, 6'b00_0000);
        // Stall blocks DRAIN->GRANT, retire ignored in DRAIN, then back-to-back op
        add(5'b11000, 6'b00_1000);
        add(5'b11110, 6'b01_1000);
        add(5'b11000, 6'b01_1000);
        add(5'b11000, 6'b10_0110);
        add(5'b10000, 6'b11_1010);
        add(5'b10010, 6'b11_1010);
        add(5'b10000, 6'b00_1000);
        add(5'b10000, 6'b01_1000);
        add(5'b00001, 6'b01_1000);
        add(5'b00000, 6'b00_0000);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        #2;
        check("reset_outputs", 32'(outs()), 32'(6'b00_0000));
`ifdef RSD_SERIALIZE_PERF_COUNTER_EN
        check("perf_reset", serialStallCycles, 32'd0);
`endif

        // IDLE hold + 4 DRAIN + 1 GRANT + 3 WAIT_RETIRE
        drive(5'b10000);
        repeat (3) drive(5'b10000);
        drive(5'b11000);
        drive(5'b11000);
        drive(5'b00000);
        drive(5'b00000);
        drive(5'b00010);
        drive(5'b00000);
        check("perf_seq_idle", 32'(state), 32'd0);
`ifdef RSD_SERIALIZE_PERF_COUNTER_EN
        check("perf_count", serialStallCycles, 32'd8);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Timeout: 15 DRAIN cycles sets the sticky flag
        drive(5'b10000);
        for (int i = 0; i < 15; i++) begin
            drive(5'b10000);
            check($sformatf("to_drain%0d", i), 32'({state, timeoutErr}), 32'(3'b01_0));
        end
        drive(5'b10000);
        check("to_set", 32'({state, timeoutErr}), 32'(3'b01_1));
        repeat (20) drive(5'b10000);
        check("to_saturated", 32'({state, timeoutErr}), 32'(3'b01_1));
        drive(5'b10001);
        check("to_flush_cycle", 32'({state, timeoutErr}), 32'(3'b01_1));
        drive(5'b00000);
        check("to_after_flush", 32'({state, timeoutErr}), 32'(3'b00_1));
        drive(5'b00000);
        check("to_sticky", 32'(timeoutErr), 32'd1);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("to_cleared_by_reset", 32'(outs()), 32'(6'b00_0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
